// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI access arbiter: one-hot state encoding and a
// counter-width helper.
package spi_arb_pkg;

    typedef enum logic [4:0] {
        StIdle     = 5'b00001,
        StStart    = 5'b00010,
        StWaitDone = 5'b00100,
        StGap      = 5'b01000,
        StFault    = 5'b10000
    } arb_state_e;

    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_priority_select
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         winner_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       valid_o
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    always_comb begin
        int unsigned j;
        j        = 0;
        winner_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (32'(ptr_i) + k) % NUM_REQ;
            if (!valid_o && req_i[j]) begin
                valid_o     = 1'b1;
                winner_o[j] = 1'b1;
                idx_o       = IdW'(j);
            end
        end
    end

endmodule

// File: rtl/spi_access_arbiter.sv
// Round-robin arbiter that shares one SPI master among NUM_REQ requesters, with
// latched operands, an inter-transfer gap and a sticky DONE watchdog.
module spi_access_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [8*NUM_REQ-1:0]          req_length_i,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            ack_o,
    output logic                          err_o,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    output logic                          busy_o,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
    output logic                          fault_o,
    output logic                          spi_enable_o,
    output logic [7:0]                    spi_length_o,
    output logic [DATA_WIDTH-1:0]         spi_data_in_o,
    input  logic [DATA_WIDTH-1:0]         spi_data_out_i,
    input  logic                          spi_done_i
);
    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned ToW  = clog2_min1(TIMEOUT_CYCLES + 1);
    localparam int unsigned GapW = clog2_min1(GAP_CYCLES + 1);

    arb_state_e            state_q;
    logic                  idle_armed_q;
    logic [IdW-1:0]        rr_ptr_q;
    logic [IdW-1:0]        grant_q;
    logic [ToW-1:0]        wd_cnt_q;
    logic [GapW-1:0]       gap_cnt_q;
    logic [NUM_REQ-1:0]    ack_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  fault_q;
    logic                  spi_enable_q;
    logic [7:0]            spi_length_q;
    logic [DATA_WIDTH-1:0] spi_data_in_q;

    logic [NUM_REQ-1:0]    sel_req;
    logic [NUM_REQ-1:0]    win_onehot;
    logic [IdW-1:0]        win_idx;
    logic                  win_valid;
    logic [7:0]            win_len;
    logic [DATA_WIDTH-1:0] win_data;
    logic [NUM_REQ-1:0]    grant_onehot;

    function automatic logic [IdW-1:0] ptr_after(input logic [IdW-1:0] idx);
        if (32'(idx) >= NUM_REQ - 1) return '0;
        return idx + 1'b1;
    endfunction

    // A requester just acknowledged has not yet had a cycle to drop its REQ.
    assign sel_req      = (state_q == StFault) ? (req_i & ~ack_q) : req_i;
    assign win_len      = req_length_i[32'(win_idx)*8 +: 8];
    assign win_data     = req_data_i[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign grant_onehot = NUM_REQ'(1) << grant_q;

    rr_priority_select #(
        .NUM_REQ(NUM_REQ)
    ) u_select (
        .req_i   (sel_req),
        .ptr_i   (rr_ptr_q),
        .winner_o(win_onehot),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    // idle_armed_q keeps IDLE from granting on its first cycle, so a requester
    // always sees its ACK for one full cycle before its REQ counts again.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            idle_armed_q  <= 1'b1;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            wd_cnt_q      <= '0;
            gap_cnt_q     <= '0;
            ack_q         <= '0;
            err_q         <= 1'b0;
            rd_data_q     <= '0;
            fault_q       <= 1'b0;
            spi_enable_q  <= 1'b0;
            spi_length_q  <= '0;
            spi_data_in_q <= '0;
        end else begin
            ack_q        <= '0;
            err_q        <= 1'b0;
            spi_enable_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    idle_armed_q <= 1'b1;
                    if (idle_armed_q && win_valid) begin
                        grant_q       <= win_idx;
                        spi_length_q  <= win_len;
                        spi_data_in_q <= win_data;
                        if (win_len == 8'd0) begin
                            ack_q    <= win_onehot;
                            err_q    <= 1'b1;
                            rr_ptr_q <= ptr_after(win_idx);
                            if (GAP_CYCLES == 0) begin
                                idle_armed_q <= 1'b0;
                            end else begin
                                state_q   <= StGap;
                                gap_cnt_q <= '0;
                            end
                        end else begin
                            spi_enable_q <= 1'b1;
                            state_q      <= StStart;
                        end
                    end
                end
                StStart: begin
                    wd_cnt_q <= '0;
                    state_q  <= StWaitDone;
                end
                StWaitDone: begin
                    if (spi_done_i) begin
                        rd_data_q <= spi_data_out_i;
                        ack_q     <= grant_onehot;
                        rr_ptr_q  <= ptr_after(grant_q);
                        if (GAP_CYCLES == 0) begin
                            state_q      <= StIdle;
                            idle_armed_q <= 1'b0;
                        end else begin
                            state_q   <= StGap;
                            gap_cnt_q <= '0;
                        end
                    end else if (32'(wd_cnt_q) + 32'd1 >= TIMEOUT_CYCLES) begin
                        ack_q    <= grant_onehot;
                        err_q    <= 1'b1;
                        fault_q  <= 1'b1;
                        rr_ptr_q <= ptr_after(grant_q);
                        state_q  <= StFault;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                StGap: begin
                    if (32'(gap_cnt_q) + 32'd1 >= GAP_CYCLES) begin
                        state_q      <= StIdle;
                        idle_armed_q <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                StFault: begin
                    if (win_valid) begin
                        ack_q    <= win_onehot;
                        err_q    <= 1'b1;
                        grant_q  <= win_idx;
                        rr_ptr_q <= ptr_after(win_idx);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack_o         = ack_q;
    assign err_o         = err_q;
    assign rd_data_o     = rd_data_q;
    assign busy_o        = (state_q != StIdle);
    assign grant_id_o    = grant_q;
    assign fault_o       = fault_q;
    assign spi_enable_o  = spi_enable_q;
    assign spi_length_o  = spi_length_q;
    assign spi_data_in_o = spi_data_in_q;

endmodule

// File: tb/tb_spi_access_arbiter.sv
// Bench for spi_access_arbiter: directed scenarios plus a randomized run against a
// transaction-level timing model, with a simple SPI master stub.
module tb_spi_access_arbiter;
    localparam int N   = 2;
    localparam int DW  = 16;
    localparam int GAP = 4;
    localparam int TO  = 100;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [N-1:0]  req_i;
    logic [8*N-1:0]  req_length_i;
    logic [DW*N-1:0] req_data_i;
    logic [N-1:0]  ack_o;
    logic          err_o;
    logic [DW-1:0] rd_data_o;
    logic          busy_o;
    logic [0:0]    grant_id_o;
    logic          fault_o;
    logic          spi_enable_o;
    logic [7:0]    spi_length_o;
    logic [DW-1:0] spi_data_in_o;
    logic [DW-1:0] spi_data_out_i;
    logic          spi_done_i;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    bit            stub_armed = 0;
    int            stub_cnt = 0;
    int            stub_lat = 0;
    logic [DW-1:0] stub_word = '0;

    always #5 clk = ~clk;

    spi_access_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_length_i(req_length_i),
        .req_data_i(req_data_i), .ack_o(ack_o), .err_o(err_o), .rd_data_o(rd_data_o),
        .busy_o(busy_o), .grant_id_o(grant_id_o), .fault_o(fault_o),
        .spi_enable_o(spi_enable_o), .spi_length_o(spi_length_o),
        .spi_data_in_o(spi_data_in_o), .spi_data_out_i(spi_data_out_i),
        .spi_done_i(spi_done_i)
    );

    // Advance one cycle; the stub raises DONE stub_lat cycles after it sees ENABLE.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        spi_done_i = 1'b0;
        if (stub_armed) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                spi_done_i     = 1'b1;
                spi_data_out_i = stub_word;
                stub_armed     = 0;
            end
        end
        if (spi_enable_o && stub_lat != 0) begin
            stub_armed = 1;
            stub_cnt   = stub_lat;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req_i = '0;
        tick();
        rst_i      = 1'b0;
        stub_armed = 0;
        spi_done_i = 1'b0;
    endtask

    task automatic wait_ack(input int max_cyc, output int at, output int n_en);
        at   = -1;
        n_en = 0;
        for (int k = 0; k < max_cyc; k++) begin
            tick();
            if (spi_enable_o) n_en++;
            if (ack_o != '0) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_en(input int max_cyc, output int at);
        at = -1;
        for (int k = 0; k < max_cyc; k++) begin
            tick();
            if (spi_enable_o) begin
                at = cyc;
                break;
            end
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_i = 1'b1;
        req_i = '0;
        req_length_i = '0;
        req_data_i = '0;
        spi_done_i = 1'b0;
        spi_data_out_i = '0;
        tick();
        tick();
        tests++;
        if ({ack_o, err_o, busy_o, fault_o, spi_enable_o} !== '0) begin
            fails++;
            $display("FAIL reset_flags: got ack=%b err=%b busy=%b fault=%b en=%b want all 0",
                     ack_o, err_o, busy_o, fault_o, spi_enable_o);
        end
        tests++;
        if ({rd_data_o, grant_id_o} !== '0) begin
            fails++;
            $display("FAIL reset_rd_gid: got rd=%h gid=%0d want 0", rd_data_o, grant_id_o);
        end
        tests++;
        if ({spi_length_o, spi_data_in_o} !== '0) begin
            fails++;
            $display("FAIL reset_spi: got len=%0d din=%h want 0", spi_length_o, spi_data_in_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_single();
        int t, at, n_en;
        do_reset();
        stub_lat = 20;
        stub_word = 16'h1234;
        req_length_i = {8'd0, 8'd2};
        req_data_i = {16'h0000, 16'hA55A};
        req_i = 2'b01;
        t = cyc;
        tick();
        tests++;
        if (spi_enable_o !== 1'b1 || spi_length_o !== 8'd2 || spi_data_in_o !== 16'hA55A) begin
            fails++;
            $display("FAIL single_start: got en=%b len=%0d din=%h want 1/2/a55a",
                     spi_enable_o, spi_length_o, spi_data_in_o);
        end
        wait_ack(40, at, n_en);
        tests++;
        if (at != t + 22 || ack_o !== 2'b01 || err_o !== 1'b0 || rd_data_o !== 16'h1234) begin
            fails++;
            $display("FAIL single_ack: got cyc=%0d ack=%b err=%b rd=%h want cyc=%0d ack=01 err=0 rd=1234",
                     at - t, ack_o, err_o, rd_data_o, 22);
        end
        tests++;
        if (n_en != 0) begin
            fails++;
            $display("FAIL single_one_enable: got %0d extra enables want 0", n_en);
        end
        req_i = '0;
        for (int k = 0; k < GAP + 3; k++) tick();
    endtask

    task automatic test_round_robin();
        int ptr, w, en_at, at, n_en, last_d;
        logic [DW-1:0] d [N];
        do_reset();
        ptr = 0;
        last_d = -1;
        for (int i = 0; i < N; i++) begin
            d[i] = DW'($urandom);
            req_data_i[i*DW +: DW] = d[i];
            req_length_i[i*8 +: 8] = 8'(i + 1);
        end
        req_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            w = rr_pick(req_i, ptr);
            stub_lat = $urandom_range(3, 10);
            stub_word = DW'($urandom);
            wait_en(40, en_at);
            tests++;
            if (en_at < 0 || 32'(grant_id_o) != w || spi_data_in_o !== d[w]) begin
                fails++;
                $display("FAIL rr_grant%0d: got gid=%0d din=%h want gid=%0d din=%h",
                         k, grant_id_o, spi_data_in_o, w, d[w]);
            end
            if (last_d >= 0) begin
                tests++;
                if (en_at - last_d != GAP + 3) begin
                    fails++;
                    $display("FAIL rr_spacing%0d: got %0d want %0d", k, en_at - last_d, GAP + 3);
                end
            end
            wait_ack(30, at, n_en);
            tests++;
            if (at != en_at + stub_lat + 1 || ack_o[w] !== 1'b1 || ack_o[1-w] !== 1'b0 ||
                rd_data_o !== stub_word) begin
                fails++;
                $display("FAIL rr_ack%0d: got cyc=%0d ack=%b rd=%h want cyc=%0d ack[%0d] rd=%h",
                         k, at, ack_o, rd_data_o, en_at + stub_lat + 1, w, stub_word);
            end
            last_d = at - 1;
            ptr = (w + 1) % N;
            d[w] = DW'($urandom);
            req_data_i[w*DW +: DW] = d[w];
        end
        req_i = '0;
        for (int k = 0; k < 30; k++) tick();
    endtask

    task automatic test_zero_length();
        int t, n_en, at, n_en2;
        do_reset();
        n_en = 0;
        req_length_i = {8'd0, 8'd3};
        req_data_i = {16'hBEEF, 16'h0F0F};
        req_i = 2'b10;
        t = cyc;
        tick();
        tests++;
        if (ack_o !== 2'b10 || err_o !== 1'b1 || spi_enable_o !== 1'b0 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL zero_ack: got ack=%b err=%b en=%b busy=%b want 10/1/0/1",
                     ack_o, err_o, spi_enable_o, busy_o);
        end
        req_i = '0;
        for (int k = 1; k < GAP; k++) begin
            tick();
            if (spi_enable_o) n_en++;
        end
        tests++;
        if (busy_o !== 1'b1) begin
            fails++;
            $display("FAIL zero_gap_busy: got %b want 1 at cycle %0d", busy_o, cyc - t);
        end
        tick();
        tests++;
        if (busy_o !== 1'b0 || n_en != 0) begin
            fails++;
            $display("FAIL zero_gap_end: got busy=%b enables=%0d want 0/0", busy_o, n_en);
        end
        // request on the first IDLE cycle: enable two cycles later
        stub_lat = 5;
        stub_word = 16'h5A5A;
        req_i = 2'b01;
        t = cyc;
        wait_en(10, at);
        tests++;
        if (at != t + 2 || spi_length_o !== 8'd3) begin
            fails++;
            $display("FAIL zero_next_grant: got cyc=%0d len=%0d want cyc=2 len=3", at - t, spi_length_o);
        end
        wait_ack(20, at, n_en2);
        req_i = '0;
        for (int k = 0; k < GAP + 3; k++) tick();
    endtask

    task automatic test_watchdog();
        int t, at, n_en, bad_en;
        do_reset();
        stub_lat = 0;
        bad_en = 0;
        req_length_i = {8'd2, 8'd1};
        req_i = 2'b01;
        t = cyc;
        wait_ack(200, at, n_en);
        tests++;
        if (at != t + 2 + TO || ack_o !== 2'b01 || err_o !== 1'b1 || fault_o !== 1'b1) begin
            fails++;
            $display("FAIL wd_timeout: got cyc=%0d ack=%b err=%b fault=%b want cyc=%0d ack=01 err=1 fault=1",
                     at - t, ack_o, err_o, fault_o, 2 + TO);
        end
        req_i = '0;
        for (int k = 0; k < 3; k++) tick();
        tests++;
        if (fault_o !== 1'b1 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL wd_sticky: got fault=%b busy=%b want 1/1", fault_o, busy_o);
        end
        req_i = 2'b01;
        tick();
        bad_en += int'(spi_enable_o);
        tests++;
        if (ack_o !== 2'b01 || err_o !== 1'b1) begin
            fails++;
            $display("FAIL wd_fault_req0: got ack=%b err=%b want 01/1", ack_o, err_o);
        end
        req_i = '0;
        tick();
        bad_en += int'(spi_enable_o);
        tests++;
        if (ack_o !== 2'b00) begin
            fails++;
            $display("FAIL wd_fault_once: got ack=%b want 00", ack_o);
        end
        req_i = 2'b11;
        tick();
        bad_en += int'(spi_enable_o);
        tests++;
        if (ack_o !== 2'b10 || err_o !== 1'b1) begin
            fails++;
            $display("FAIL wd_fault_rr1: got ack=%b err=%b want 10/1", ack_o, err_o);
        end
        req_i = 2'b01;
        tick();
        bad_en += int'(spi_enable_o);
        tests++;
        if (ack_o !== 2'b01 || err_o !== 1'b1) begin
            fails++;
            $display("FAIL wd_fault_rr0: got ack=%b err=%b want 01/1", ack_o, err_o);
        end
        req_i = '0;
        tick();
        bad_en += int'(spi_enable_o);
        tests++;
        if (bad_en != 0 || ack_o !== 2'b00) begin
            fails++;
            $display("FAIL wd_fault_quiet: got enables=%0d ack=%b want 0/00", bad_en, ack_o);
        end
    endtask

    task automatic test_operand_stability();
        int t, at;
        logic [DW-1:0] d0;
        do_reset();
        d0 = DW'($urandom);
        stub_lat = 15;
        stub_word = DW'($urandom);
        req_length_i = {8'd1, 8'd3};
        req_data_i = {16'h0000, d0};
        req_i = 2'b01;
        t = cyc;
        tick();
        tick();
        req_i = '0;
        at = -1;
        for (int k = 0; k < 40; k++) begin
            req_length_i = 16'($urandom);
            req_data_i = 32'($urandom);
            tick();
            if (ack_o != '0) begin
                at = cyc;
                break;
            end
            tests++;
            if (spi_length_o !== 8'd3 || spi_data_in_o !== d0) begin
                fails++;
                $display("FAIL stable_operands: got len=%0d din=%h want 3/%h",
                         spi_length_o, spi_data_in_o, d0);
            end
        end
        tests++;
        if (at != t + 17 || ack_o !== 2'b01 || rd_data_o !== stub_word) begin
            fails++;
            $display("FAIL stable_ack: got cyc=%0d ack=%b rd=%h want cyc=17 ack=01 rd=%h",
                     at - t, ack_o, rd_data_o, stub_word);
        end
        for (int k = 0; k < GAP + 3; k++) tick();
    endtask

    task automatic test_reset_mid();
        int bad;
        do_reset();
        bad = 0;
        stub_lat = 10;
        stub_word = 16'hCAFE;
        req_length_i = {8'd0, 8'd2};
        req_i = 2'b01;
        tick();
        tick();
        tick();
        rst_i = 1'b1;
        req_i = '0;
        tick();
        rst_i = 1'b0;
        tests++;
        if ({ack_o, err_o, busy_o, fault_o, spi_enable_o, rd_data_o, grant_id_o,
             spi_length_o, spi_data_in_o} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got ack=%b err=%b busy=%b fault=%b en=%b rd=%h gid=%0d len=%0d din=%h want all 0",
                     ack_o, err_o, busy_o, fault_o, spi_enable_o, rd_data_o, grant_id_o,
                     spi_length_o, spi_data_in_o);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ack_o != '0 || busy_o || spi_enable_o || rd_data_o != '0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL midreset_done_ignored: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_random();
        int ptr, ready, e_en, e_ack, e_w;
        logic e_err;
        logic [DW-1:0] e_rd, e_data;
        logic [7:0] e_len;
        logic [N-1:0] ev;
        do_reset();
        ready = cyc;
        ptr = 0;
        e_en = -1;
        e_ack = -1;
        e_w = 0;
        e_err = 1'b0;
        e_rd = '0;
        e_data = '0;
        e_len = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (ack_o[i]) begin
                    req_i[i] = 1'b0;
                end else if (!req_i[i] && $urandom_range(0, 3) == 0) begin
                    req_i[i] = 1'b1;
                    req_length_i[i*8 +: 8] = ($urandom_range(0, 5) == 0) ? 8'd0 :
                                             8'($urandom_range(1, 4));
                    req_data_i[i*DW +: DW] = DW'($urandom);
                end
            end
            if (cyc >= ready && req_i != '0) begin
                e_w = rr_pick(req_i, ptr);
                ptr = (e_w + 1) % N;
                e_len = req_length_i[e_w*8 +: 8];
                e_data = req_data_i[e_w*DW +: DW];
                if (e_len == 8'd0) begin
                    e_en = -1;
                    e_ack = cyc + 1;
                    e_err = 1'b1;
                end else begin
                    stub_lat = $urandom_range(1, 12);
                    stub_word = DW'($urandom);
                    e_en = cyc + 1;
                    e_ack = cyc + 2 + stub_lat;
                    e_err = 1'b0;
                    e_rd = stub_word;
                end
                ready = e_ack + 1 + GAP;
            end
            tick();
            tests++;
            if (spi_enable_o !== (cyc == e_en)) begin
                fails++;
                $display("FAIL rand_enable: got %b want %b at cycle %0d", spi_enable_o, cyc == e_en, cyc);
            end
            if (cyc == e_en) begin
                tests++;
                if (32'(grant_id_o) != e_w || spi_length_o !== e_len || spi_data_in_o !== e_data) begin
                    fails++;
                    $display("FAIL rand_operands: got gid=%0d len=%0d din=%h want %0d/%0d/%h",
                             grant_id_o, spi_length_o, spi_data_in_o, e_w, e_len, e_data);
                end
            end
            ev = '0;
            if (cyc == e_ack) ev[e_w] = 1'b1;
            tests++;
            if (ack_o !== ev) begin
                fails++;
                $display("FAIL rand_ack: got %b want %b at cycle %0d", ack_o, ev, cyc);
            end
            if (cyc == e_ack) begin
                tests++;
                if (err_o !== e_err || (!e_err && rd_data_o !== e_rd)) begin
                    fails++;
                    $display("FAIL rand_result: got err=%b rd=%h want err=%b rd=%h",
                             err_o, rd_data_o, e_err, e_rd);
                end
            end
            // stray DONE while no transfer is outstanding must be ignored
            if (!stub_armed && !spi_done_i && $urandom_range(0, 15) == 0) begin
                spi_done_i = 1'b1;
                spi_data_out_i = DW'($urandom);
            end
        end
        req_i = '0;
        for (int k = 0; k < 30; k++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_length();
        test_watchdog();
        test_operand_stability();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_access_arbiter.md
# spi_access_arbiter

Round-robin arbiter and transaction sequencer that shares one `SPI_MASTER` instance among `NUM_REQ` requesters, such as the DAC and gain-control register writers in the signal generator. It latches the winning request and issues a single-cycle `ENABLE` to the master. It holds `LENGTH` and `DATA_IN` stable for the whole transfer, waits for `DONE`, and returns the received word. A programmable inter-transfer gap and a `DONE` watchdog protect the bus.

## Interface
- `NUM_REQ`, default 2: number of requesters, range 2..8.
- `DATA_WIDTH`, default 16: must match the master's `DATA_WIDTH`.
- `GAP_CYCLES`, default 4: minimum `CLK` cycles between `SPI_DONE` and the next `SPI_ENABLE`. 0 is allowed.
- `TIMEOUT_CYCLES`, default 65535: maximum cycles from `SPI_ENABLE` to `SPI_DONE` before a fault.
- `CLK` in 1: single clock for all logic, shared with the SPI master.
- `RESET` in 1: synchronous, active-high reset.
- `REQ` in `NUM_REQ`: per-requester request level.
- `REQ_LENGTH` in `8*NUM_REQ`: transfer length in bytes. Slice i belongs to requester i.
- `REQ_DATA` in `DATA_WIDTH*NUM_REQ`: transmit word. Slice i belongs to requester i.
- `ACK` in/out: output, `NUM_REQ` wide. One-cycle completion pulse, one-hot.
- `ERR` out 1: one-cycle pulse coincident with `ACK` when the transfer failed.
- `RD_DATA` out `DATA_WIDTH`: received word. Valid in the `ACK` cycle and held until the next `ACK`.
- `BUSY` out 1: high in every state other than IDLE.
- `GRANT_ID` out `$clog2(NUM_REQ)`: index of the current or last granted requester.
- `FAULT` out 1: sticky watchdog fault, cleared only by `RESET`.
- `SPI_ENABLE` out 1: connects to the master's `ENABLE`.
- `SPI_LENGTH` out 8: connects to the master's `LENGTH`.
- `SPI_DATA_IN` out `DATA_WIDTH`: connects to the master's `DATA_IN`.
- `SPI_DATA_OUT` in `DATA_WIDTH`: from the master's `DATA_OUT`.
- `SPI_DONE` in 1: from the master's `DONE` tick.

## Operation
- States: IDLE, START, WAIT_DONE, GAP, FAULT.
- **IDLE**
  - If any `REQ` bit is high, select a winner by round-robin. Priority starts at `rr_ptr` and wraps.
  - Latch the winner's `REQ_LENGTH` and `REQ_DATA` into `SPI_LENGTH`/`SPI_DATA_IN`. Set `GRANT_ID`. Go to START.
  - If the latched length is 0, do not start the master. Instead pulse `ACK[winner]` and `ERR`, then go to GAP.
- **START**: `SPI_ENABLE` is high for exactly this cycle. Clear the watchdog counter. Go to WAIT_DONE.
- **WAIT_DONE**
  - On `SPI_DONE`: capture `SPI_DATA_OUT` into `RD_DATA`, pulse `ACK[GRANT_ID]`, set `rr_ptr = GRANT_ID+1` (mod `NUM_REQ`), then go to GAP.
  - If the counter reaches `TIMEOUT_CYCLES` first: pulse `ACK` and `ERR`, set `FAULT`, go to FAULT.
- **GAP**: count `GAP_CYCLES`, then go to IDLE. With `GAP_CYCLES`=0, go directly to IDLE.
- **FAULT**: terminal state until `RESET`.
  - Any `REQ` bit that is high gets `ACK`+`ERR` the cycle after it is sampled, one requester per cycle, round-robin.
  - `SPI_ENABLE` stays low.
- **Requester rules**
  - Hold `REQ` and the data slices stable until `ACK`.
  - Dropping `REQ` before a grant withdraws the request.
  - Changes after the grant are ignored, because the operands are latched.
  - `REQ` still high in the cycle after `ACK` is treated as a new request. It then has the lowest priority.
- **Latched outputs**: `SPI_LENGTH`/`SPI_DATA_IN` are stable from START through the end of WAIT_DONE. The master compares `LENGTH` on every cycle and loads `DATA_IN` at each word, so it requires this.
- **Reset values**: `ACK`=0, `ERR`=0, `RD_DATA`=0, `BUSY`=0, `GRANT_ID`=0, `FAULT`=0, `SPI_ENABLE`=0, `SPI_LENGTH`=0, `SPI_DATA_IN`=0, `rr_ptr`=0, state IDLE.
- **Reset mid-transfer**: the arbiter returns to IDLE. The master must share the same reset domain, or be idle, before the next grant. The arbiter does not check this.

## Timing
- `REQ` is high at cycle t in IDLE. START (`SPI_ENABLE`=1) is at t+1. WAIT_DONE is from t+2.
- `SPI_DONE` is sampled at cycle d. `ACK`/`ERR`/`RD_DATA` are valid at d+1. IDLE is reached at d+1+`GAP_CYCLES`.
- The earliest next `SPI_ENABLE` is at d+3+`GAP_CYCLES`.
- `SPI_DONE` seen in any state other than WAIT_DONE is ignored.
- The watchdog counts every WAIT_DONE cycle. The timeout fires on the cycle the count equals `TIMEOUT_CYCLES`.
- Counter widths are `$clog2(TIMEOUT_CYCLES+1)` and `$clog2(GAP_CYCLES+1)` (minimum 1).

## Structure
- A shared package `spi_arb_pkg` holds:
  - the state encoding, one-hot, 5 bits;
  - the function `clog2_min1`.
- Sub-module `rr_priority_select`: purely combinational, takes `REQ` and `rr_ptr`, and returns a one-hot winner and its index. It is reused by IDLE and FAULT.

## Test plan
- **Single request**: `REQ`=01, length 2, data 0xA55A, master stub returns 0x1234 with `DONE` 20 cycles after `ENABLE`. Expect:
  - one `SPI_ENABLE` pulse at t+1;
  - `ACK`=01 with `RD_DATA`=0x1234 at d+1;
  - `ERR`=0.
- **Round-robin**: `REQ`=11 held continuously. Expect grants alternating 0,1,0,1.
  - Successive `SPI_ENABLE` pulses are ≥ `GAP_CYCLES`+2 cycles apart after each `DONE`.
- **Zero length**: requester 1 with length 0. Expect `ACK`=10 and `ERR`=1, no `SPI_ENABLE`, and GAP observed.
- **Watchdog**: `TIMEOUT_CYCLES`=100 with the stub never asserting `DONE`. Expect:
  - `ACK`+`ERR` at cycle 100 of WAIT_DONE;
  - `FAULT`=1;
  - a subsequent `REQ`=01 gets `ACK`+`ERR` with no `SPI_ENABLE`.
- **Operand stability**: change `REQ_DATA`/`REQ_LENGTH` and drop `REQ` during WAIT_DONE. Expect `SPI_DATA_IN`/`SPI_LENGTH` unchanged and `ACK` still issued.
- **Reset mid-transfer**: assert `RESET` for 1 cycle in WAIT_DONE. Expect all outputs at their reset values the next cycle, and a later `DONE` ignored.
